// File: rtl/async_fifo_1clk_pkg.sv
// Shared sizing for the single-clock FIFO slice.
//   DEF_DATA_WIDTH : default word width in bits
//   DEF_ADDR_WIDTH : default log2 of the FIFO depth
//   DEF_DEPTH      : number of entries at the default address width
//   DEF_PTR_WIDTH  : pointer width, one extra bit used as the wrap bit
package async_fifo_1clk_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;
  localparam int unsigned DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

endpackage

// File: rtl/async_fifo_1clk_mem.sv
// Simple dual-port RAM, DEPTH x DATA_WIDTH, for the FIFO storage.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears only the read register
//   we    : write enable; mem[waddr] <= wdata
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata <= mem[raddr], otherwise rdata holds
//   raddr : read address
//   rdata : registered read data
module fifo_mem
  import async_fifo_1clk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/async_fifo_1clk.sv
// Single-clock byte FIFO with request-style write/read ports and full/empty flags.
// Requests that would overflow or underflow are ignored.
//   wclk   : the single clock, rising edge
//   wrst   : synchronous active-high reset, empties the FIFO and clears rdata
//   wreq   : write request, accepted when !wfull
//   rreq   : read request, accepted when !rempty
//   wdata  : write data, sampled on an accepted write
//   rdata  : registered read data, valid one edge after an accepted read
//   wfull  : FIFO holds DEPTH entries
//   rempty : FIFO holds no entries
module async_fifo_1clk
  import async_fifo_1clk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wreq,
  input  logic                  rreq,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty
);

  localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic                 do_wr;
  logic                 do_rd;

  // Equal pointers mean empty; equal addresses with differing wrap bits mean full.
  assign rempty = (wptr == rptr);
  assign wfull  = (wptr[PTR_WIDTH-1] != rptr[PTR_WIDTH-1]) &&
                  (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  // Acceptance uses the flags ahead of the edge, so full+both reads only and
  // empty+both writes only.
  assign do_wr = wreq && !wfull && !wrst;
  assign do_rd = rreq && !rempty && !wrst;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + PTR_WIDTH'(1);
      end
      if (do_rd) begin
        rptr <= rptr + PTR_WIDTH'(1);
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (wclk),
    .rst   (wrst),
    .we    (do_wr),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (do_rd),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_async_fifo_1clk.sv
module tb_async_fifo_1clk;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       wreq;
  logic       rreq;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;

  int errors = 0;
  int checks = 0;

  async_fifo_1clk #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .wreq   (wreq),
    .rreq   (rreq),
    .wdata  (wdata),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
  );

  always #5 wclk = ~wclk;

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fillv [16] = '{8'd15, 8'd19, 8'd107, 8'd5, 8'd8, 8'd50, 8'd244, 8'd67,
                             8'd244, 8'd88, 8'd188, 8'd32, 8'd132, 8'd232, 8'd1, 8'd2};

  initial begin
    // 1. Reset with a write request held: the write must be ignored
    wrst = 1'b1; wreq = 1'b1; rreq = 1'b0; wdata = 8'd4;
    step();
    step();
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_wfull",  32'(wfull),  32'd0);
    chk("rst_rdata",  32'(rdata),  32'd0);
    wrst = 1'b0; wreq = 1'b0;
    step();
    chk("post_rst_rempty", 32'(rempty), 32'd1);

    // 2. Fill to 16, then a dropped 17th write
    for (int i = 0; i < 16; i++) begin
      wreq = 1'b1; wdata = fillv[i];
      step();
      chk($sformatf("fill_wfull_%0d", i),  32'(wfull),  (i == 15) ? 32'd1 : 32'd0);
      chk($sformatf("fill_rempty_%0d", i), 32'(rempty), 32'd0);
    end
    wdata = 8'd99;
    step();
    chk("ovf_wfull", 32'(wfull), 32'd1);
    wreq = 1'b0;

    // 3. Drain with 17 read requests; the 17th is blocked and rdata holds
    rreq = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("drain_rdata_%0d", k),  32'(rdata),  32'(fillv[k]));
      chk($sformatf("drain_rempty_%0d", k), 32'(rempty), (k == 15) ? 32'd1 : 32'd0);
    end
    step();
    chk("udf_rdata",  32'(rdata),  32'd2);
    chk("udf_rempty", 32'(rempty), 32'd1);
    rreq = 1'b0;

    // 4. Concurrent write+read from empty, 40 cycles; pointers wrap past 32
    wreq = 1'b1; rreq = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wdata = 8'(c);
      step();
      chk($sformatf("conc_rdata_%0d", c), 32'(rdata), (c == 0) ? 32'd2 : 32'(c - 1));
      chk($sformatf("conc_rempty_%0d", c), 32'(rempty), 32'd0);
    end
    wreq = 1'b0;
    step();
    chk("conc_last_rdata",  32'(rdata),  32'd39);
    chk("conc_last_rempty", 32'(rempty), 32'd1);
    rreq = 1'b0;

    // 5. At full, write and read together: only the read is accepted
    wreq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(8'hA0 + i);
      step();
    end
    chk("full2_wfull", 32'(wfull), 32'd1);
    rreq = 1'b1; wdata = 8'h55;
    step();
    chk("both_rdata", 32'(rdata), 32'hA0);
    chk("both_wfull", 32'(wfull), 32'd0);
    wreq = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk($sformatf("both_drain_%0d", k), 32'(rdata), 32'(8'hA0 + k));
    end
    chk("both_drain_rempty", 32'(rempty), 32'd1);
    step();
    chk("both_dropped_rdata", 32'(rdata), 32'hAF);
    rreq = 1'b0;

    // 6. Reset with 5 entries stored, then only new data comes out
    wreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'(8'h30 + i);
      step();
    end
    wreq = 1'b0;
    chk("mid_pre_rempty", 32'(rempty), 32'd0);
    wrst = 1'b1;
    step();
    chk("mid_rempty", 32'(rempty), 32'd1);
    chk("mid_wfull",  32'(wfull),  32'd0);
    chk("mid_rdata",  32'(rdata),  32'd0);
    wrst = 1'b0; wreq = 1'b1; wdata = 8'h77;
    step();
    wreq = 1'b0; rreq = 1'b1;
    step();
    chk("mid_new_rdata",  32'(rdata),  32'h77);
    chk("mid_new_rempty", 32'(rempty), 32'd1);
    rreq = 1'b0;
    step();
    chk("mid_hold_rdata", 32'(rdata), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
